// File: rtl/force_cache_accum.sv
// Per-cell force cache: accumulates ring forces per particle, read-and-clear drain.
// Ports: clk, rst (async active-low); i_force/i_parid/i_force_valid accumulate
// beats; i_rd_en/i_rd_parid -> o_rd_ready, o_rd_force, o_rd_valid (read-and-clear);
// o_init_done, o_busy, o_overflow status. Macro FORCE_CACHE_SAT_EN: saturating add.
module force_cache_accum #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3*DATA_WIDTH-1:0]      i_force,
  input  logic [PARTICLE_ID_WIDTH-1:0] i_parid,
  input  logic                         i_force_valid,
  input  logic                         i_rd_en,
  input  logic [PARTICLE_ID_WIDTH-1:0] i_rd_parid,
  output logic                         o_rd_ready,
  output logic [3*DATA_WIDTH-1:0]      o_rd_force,
  output logic                         o_rd_valid,
  output logic                         o_init_done,
  output logic                         o_busy,
  output logic                         o_overflow
);

  localparam int AW    = PARTICLE_ID_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int FW    = 3 * DATA_WIDTH;
  localparam int DEPTH = 2 ** PARTICLE_ID_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic            init_done_q;

  logic [FW-1:0]   mem_q [DEPTH];
  logic [FW-1:0]   rdata_q;

  logic            s1_vld_q, s1_rd_q;
  logic [AW-1:0]   s1_id_q;
  logic [FW-1:0]   s1_frc_q;

  logic            s2_vld_q, s2_rd_q;
  logic [AW-1:0]   s2_id_q;
  logic [FW-1:0]   s2_op_q, s2_frc_q;

  logic            w_vld_q;
  logic [AW-1:0]   w_id_q;
  logic [FW-1:0]   w_data_q;

  logic [FW-1:0]   rd_force_q;
  logic            rd_valid_q;
  logic            ovf_q;

  logic            s0_acc, s0_rd, s0_vld;
  logic [AW-1:0]   s0_id;
  logic [FW-1:0]   s1_op_d;
  logic [FW-1:0]   s2_sum, s2_res;
  logic [2:0]      s2_cov;
  logic            s2_ovf;
  logic            ovf_d;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [FW-1:0]   wdata;

  // Returns {overflow, sum} for one component.
  function automatic logic [DW:0] cadd(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW-1:0] s;
    logic          ov;
    s  = a + b;
    ov = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
`ifdef FORCE_CACHE_SAT_EN
    if (ov) s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                        : {1'b0, {(DW-1){1'b1}}};
`endif
    return {ov, s};
  endfunction

  // Accumulate beats win the shared RAM read port.
  assign o_rd_ready = init_done_q & ~i_force_valid;
  assign s0_acc     = i_force_valid & init_done_q;
  assign s0_rd      = i_rd_en & o_rd_ready;
  assign s0_vld     = s0_acc | s0_rd;
  assign s0_id      = s0_acc ? i_parid : i_rd_parid;

  for (genvar c = 0; c < 3; c++) begin : g_add
    assign {s2_cov[c], s2_sum[c*DW +: DW]} =
      cadd(s2_op_q[c*DW +: DW], s2_frc_q[c*DW +: DW]);
  end

  // A read leaves zero behind.
  assign s2_res = s2_rd_q ? '0 : s2_sum;
  assign s2_ovf = s2_vld_q & ~s2_rd_q & (|s2_cov);

  // S2 is newer than the last write; the write covers a
  // RAM read that raced the previous write-back.
  always_comb begin
    s1_op_d = rdata_q;
    if (s2_vld_q && s2_id_q == s1_id_q)
      s1_op_d = s2_res;
    else if (w_vld_q && w_id_q == s1_id_q)
      s1_op_d = w_data_q;
  end

  assign ovf_d = ovf_q | s2_ovf
               | (i_force_valid & ~init_done_q);

  always_comb begin
    we    = s2_vld_q;
    waddr = s2_id_q;
    wdata = s2_res;
    if (state_q == ST_INIT) begin
      we    = 1'b1;
      waddr = cnt_q;
      wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[s0_id];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {AW{1'b1}}) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: ;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q   <= 1'b0;
      s1_rd_q    <= 1'b0;
      s1_id_q    <= '0;
      s1_frc_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_rd_q    <= 1'b0;
      s2_id_q    <= '0;
      s2_op_q    <= '0;
      s2_frc_q   <= '0;
      w_vld_q    <= 1'b0;
      w_id_q     <= '0;
      w_data_q   <= '0;
      rd_force_q <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_vld_q   <= s0_vld;
      s1_rd_q    <= s0_rd;
      s1_id_q    <= s0_id;
      s1_frc_q   <= i_force;
      s2_vld_q   <= s1_vld_q;
      s2_rd_q    <= s1_rd_q;
      s2_id_q    <= s1_id_q;
      s2_op_q    <= s1_op_d;
      s2_frc_q   <= s1_frc_q;
      w_vld_q    <= s2_vld_q;
      w_id_q     <= s2_id_q;
      w_data_q   <= s2_res;
      rd_valid_q <= s1_vld_q & s1_rd_q;
      if (s1_vld_q && s1_rd_q)
        rd_force_q <= s1_op_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_rd_force  = rd_force_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_init_done = init_done_q;
  assign o_busy      = s0_vld | s1_vld_q | s2_vld_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_force_cache_accum.sv
// Self-checking bench for force_cache_accum against a sequential
// per-particle accumulate / read-and-clear reference model.
module tb_force_cache_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] i_force;
  logic [6:0]  i_parid;
  logic        i_force_valid;
  logic        i_rd_en;
  logic [6:0]  i_rd_parid;
  logic        o_rd_ready;
  logic [95:0] o_rd_force;
  logic        o_rd_valid;
  logic        o_init_done;
  logic        o_busy;
  logic        o_overflow;

  force_cache_accum dut (
    .clk(clk), .rst(rst),
    .i_force(i_force), .i_parid(i_parid),
    .i_force_valid(i_force_valid),
    .i_rd_en(i_rd_en), .i_rd_parid(i_rd_parid),
    .o_rd_ready(o_rd_ready), .o_rd_force(o_rd_force),
    .o_rd_valid(o_rd_valid), .o_init_done(o_init_done),
    .o_busy(o_busy), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [95:0] v;
  } rd_exp_t;

  logic [95:0] model [128];
  rd_exp_t     exp_q [$];
  logic [95:0] last_rd;
  bit          ovf_exp;
  bit          init_exp;
  bit          h1, h2;
  int          cycle;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Signed 32-bit add per component, wrap or clamp on overflow.
  task automatic model_add(input int id, input logic [95:0] f);
    longint s;
    logic [95:0] r;
    r = model[id];
    for (int c = 0; c < 3; c++) begin
      s = longint'($signed(r[c*32 +: 32])) + longint'($signed(f[c*32 +: 32]));
      if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
        ovf_exp = 1'b1;
`ifdef FORCE_CACHE_SAT_EN
        s = (s > 0) ? 64'sd2147483647 : -64'sd2147483648;
`endif
      end
      r[c*32 +: 32] = s[31:0];
    end
    model[id] = r;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model[i] = '0;
    exp_q.delete();
    last_rd  = '0;
    ovf_exp  = 1'b0;
    init_exp = 1'b0;
    h1 = 1'b0;
    h2 = 1'b0;
  endtask

  task automatic cyc();
    bit acc, racc;
    rd_exp_t e;
    acc  = i_force_valid && init_exp;
    racc = i_rd_en && init_exp && !i_force_valid;
    #1;
    chk("rd_ready", o_rd_ready, init_exp && !i_force_valid);
    chk("busy", o_busy, acc || racc || h1 || h2);
    if (acc) model_add(int'(i_parid), i_force);
    if (racc) begin
      exp_q.push_back('{cycle + 2, model[i_rd_parid]});
      model[i_rd_parid] = '0;
    end
    h2 = h1;
    h1 = acc || racc;
    @(posedge clk);
    cycle++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
      e = exp_q.pop_front();
      chk("rd_valid", o_rd_valid, 1'b1);
      chk("rd_force", o_rd_force, e.v);
      last_rd = e.v;
    end else begin
      chk("rd_valid_idle", o_rd_valid, 1'b0);
      chk("rd_force_hold", o_rd_force, last_rd);
    end
  endtask

  task automatic idle(input int n);
    i_force_valid = 1'b0;
    i_rd_en       = 1'b0;
    repeat (n) cyc();
    chk("overflow", o_overflow, ovf_exp);
  endtask

  task automatic beat(input int id, input logic [95:0] f);
    i_force_valid = 1'b1;
    i_parid       = id[6:0];
    i_force       = f;
    i_rd_en       = 1'b0;
    cyc();
    i_force_valid = 1'b0;
  endtask

  task automatic rd(input int id);
    i_force_valid = 1'b0;
    i_rd_en       = 1'b1;
    i_rd_parid    = id[6:0];
    cyc();
    i_rd_en       = 1'b0;
  endtask

  // Counts edges from reset release to o_init_done; optionally pokes
  // a read and a dropped force beat while the sweep is running.
  task automatic wait_init(input bit poke);
    int n;
    n = 0;
    i_rd_en       = poke;
    i_rd_parid    = 7'd0;
    i_force_valid = 1'b0;
    #1;
    if (poke) chk("init_rd_ready", o_rd_ready, 1'b0);
    while (!o_init_done && n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        i_rd_en       = 1'b0;
        i_force_valid = poke;
      end else begin
        i_force_valid = 1'b0;
      end
    end
    if (poke) ovf_exp = 1'b1;
    n_chk++;
    assert (n == 128 || n == 129) else begin
      n_fail++;
      $error("FAIL init_cycles: observed %0d expected 128", n);
    end
    init_exp = 1'b1;
    chk("init_ovf", o_overflow, ovf_exp);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_force", o_rd_force, '0);
    chk("rst_rd_valid", o_rd_valid, 1'b0);
    chk("rst_init_done", o_init_done, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_overflow", o_overflow, 1'b0);
    chk("rst_rd_ready", o_rd_ready, 1'b0);
  endtask

  function automatic logic [95:0] vec(input int z, input int y,
                                      input int x);
    return {z[31:0], y[31:0], x[31:0]};
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cycle  = 0;
    model_reset();
    rst           = 1'b0;
    i_force       = '0;
    i_parid       = '0;
    i_force_valid = 1'b0;
    i_rd_en       = 1'b0;
    i_rd_parid    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    wait_init(1'b0);

    for (int i = 0; i < 128; i++) rd(i);
    idle(3);

    beat(1, vec(3, 2, 1));
    idle(2);
    rd(1);
    rd(1);
    idle(3);

    for (int k = 1; k <= 4; k++) beat(5, vec(0, 0, k));
    rd(5);
    idle(3);

    i_force_valid = 1'b1;
    i_parid       = 7'd7;
    i_force       = vec(0, 0, 4);
    i_rd_en       = 1'b1;
    i_rd_parid    = 7'd7;
    cyc();
    rd(7);
    beat(7, vec(0, 0, 9));
    rd(7);
    idle(3);

    for (int k = 0; k < 300; k++) begin
      i_force_valid = ($urandom_range(1) == 1);
      i_parid       = 7'($urandom_range(7));
      i_force       = vec(int'($urandom_range(2000)) - 1000,
                          int'($urandom_range(2000)) - 1000,
                          int'($urandom_range(2000)) - 1000);
      i_rd_en       = ($urandom_range(9) < 4);
      i_rd_parid    = 7'($urandom_range(7));
      cyc();
    end
    idle(3);
    for (int i = 0; i < 8; i++) rd(i);
    idle(3);

    rd(2);
    beat(2, vec(0, 0, 32'h7FFF_FFFF));
    beat(2, vec(0, 0, 1));
    rd(2);
    idle(4);

    beat(3, vec(1, 1, 1));
    beat(4, vec(2, 2, 2));
    beat(3, vec(3, 3, 3));
    i_force_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_init(1'b1);
    for (int i = 0; i < 128; i++) rd(i);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/force_cache_accum.md
Name: force_cache_accum

Overview:
- Per-cell force cache directly downstream of the force output ring.
- Consumes the ring's delivered neighbour forces (force + particle id + valid) and accumulates them per particle into on-chip memory via a read-modify-write pipeline with hazard forwarding.
- The motion-update stage drains totals with read-and-clear reads.
- One instance per cell.

Parameters:
- PARTICLE_ID_WIDTH, 7, particle index width; depth = 2**PARTICLE_ID_WIDTH.
- DATA_WIDTH, 32, width of one force component, treated as two's-complement fixed point.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_force  in  3*DATA_WIDTH  {z,y,x} force from ring (ring's o_nb_force_to_force_cache)
- i_parid  in  PARTICLE_ID_WIDTH  target particle
- i_force_valid  in  1  force beat valid; no backpressure, always accepted when o_init_done=1
- i_rd_en  in  1  read-and-clear request
- i_rd_parid  in  PARTICLE_ID_WIDTH  particle to read
- o_rd_ready  out  1  read accepted this cycle when high with i_rd_en
- o_rd_force  out  3*DATA_WIDTH  accumulated force
- o_rd_valid  out  1  o_rd_force valid
- o_init_done  out  1  clear sweep finished
- o_busy  out  1  any pipeline stage valid
- o_overflow  out  1  sticky: any component add overflowed

Behaviour:
- Reset: all outputs 0, all pipeline valids 0, FSM = INIT, sweep counter 0. Reset asserted mid-operation aborts in-flight updates and reads and restarts INIT.
- FSM INIT: writes zero to address = counter each cycle, counter+1. Last address goes to RUN with o_init_done=1 next cycle.
  - i_force_valid during INIT is dropped and sets o_overflow.
  - o_rd_ready=0 in INIT.
- FSM RUN: stays until reset.
- Memory: 1-cycle synchronous-read dual-port RAM (one read port, one write port).
- Accumulate pipeline:
  - S0 issue read of i_parid.
  - S1 RAM data returns.
  - S2 add per component, register result, write back at end of S2.
  - Throughput 1 update/cycle.
- Forwarding: S1 operand is replaced by the S2 result if same parid is valid in S2, or by the result written in the prior cycle if same parid. Back-to-back updates to one particle must sum exactly.
- Arithmetic:
  - Per-component DATA_WIDTH add, wrap-around.
  - Overflow (operands same sign, result sign differs) sets o_overflow. Only reset clears it.
- Read arbitration: the single read port is shared. An accumulate has priority, so o_rd_ready = o_init_done & ~i_force_valid.
- Read-and-clear: accepted read at cycle t uses the same S0/S1/S2 stages and forwarding.
  - o_rd_force/o_rd_valid are registered at t+2.
  - Zero is written back in S2.
  - An accumulate to the same particle accepted at t+1 or later adds onto 0.
- o_rd_valid is a 1-cycle pulse per accepted read; o_rd_force holds its value otherwise.
- o_busy = OR of S0/S1/S2 valids.

Optional Feature:
- FORCE_CACHE_SAT_EN defined: component add saturates to the most-positive or most-negative value on overflow; o_overflow is still set.
- Undefined: two's-complement wrap.

Test Plan:
- Reset release -> o_init_done rises after exactly 2**PARTICLE_ID_WIDTH=128 cycles (+1). Reading all 128 ids returns 0.
- Single beat parid=1 force {3,2,1} then read id 1 -> o_rd_force={3,2,1}, o_rd_valid pulses 2 cycles after accept. A second read of id 1 -> {0,0,0}.
- Four consecutive cycles of parid=5, x=1,2,3,4 -> read id 5 gives x=10 (forwarding, no lost update).
- i_force_valid and i_rd_en in the same cycle -> o_rd_ready=0, read retried next cycle is accepted. A read of id 7 at t plus a force (x=9) to id 7 at t+1 -> read returns old value; subsequent read returns 9.
- Accumulate x=0x7FFFFFFF then x=1 to id 2 -> wrap gives 0x80000000 with o_overflow=1. With FORCE_CACHE_SAT_EN the result is 0x7FFFFFFF with o_overflow=1.
- Assert rst mid-stream with 3 updates in flight -> all outputs 0 immediately, INIT re-runs, all entries read 0 afterward.
